// File: rtl/sram_access_seq_pkg.sv
// Shared command codes, FSM state encoding and default widths for the SRAM access sequencer.
package sram_seq_pkg;

    localparam int ADDR_W_DEF = 21;
    localparam int DATA_W_DEF = 8;

    localparam logic [2:0] CMD_NOP       = 3'd0;
    localparam logic [2:0] CMD_READ      = 3'd1;
    localparam logic [2:0] CMD_WRITE     = 3'd2;
    localparam logic [2:0] CMD_READ_INC  = 3'd3;
    localparam logic [2:0] CMD_WRITE_INC = 3'd4;
    localparam logic [2:0] CMD_INC       = 3'd5;
    localparam logic [2:0] CMD_CLR       = 3'd6;
    localparam logic [2:0] CMD_RSVD      = 3'd7;

    localparam logic [3:0] ST_IDLE    = 4'd0;
    localparam logic [3:0] ST_R_SETUP = 4'd1;
    localparam logic [3:0] ST_R_WAIT  = 4'd2;
    localparam logic [3:0] ST_R_DONE  = 4'd3;
    localparam logic [3:0] ST_W_SETUP = 4'd4;
    localparam logic [3:0] ST_W_PULSE = 4'd5;
    localparam logic [3:0] ST_W_HOLD  = 4'd6;

    function automatic logic cmd_auto_inc(input logic [2:0] cmd);
        return (cmd == CMD_READ_INC) || (cmd == CMD_WRITE_INC);
    endfunction

endpackage

// File: rtl/sram_access_seq_if.sv
// SRAM pin bundle; the sequencer drives it as master, the SRAM side (or its model) is the slave.
interface sram_access_seq_if
    import sram_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) ();

    logic [ADDR_W-1:0] sram_addr;
    logic [DATA_W-1:0] sram_din;
    logic [DATA_W-1:0] sram_dout;
    logic              sram_doe;
    logic              sram_oe_n;
    logic              sram_we_n;
    logic              sram_ce_n;

    modport master (
        output sram_addr, sram_dout, sram_doe, sram_oe_n, sram_we_n, sram_ce_n,
        input  sram_din
    );

    modport slave (
        input  sram_addr, sram_dout, sram_doe, sram_oe_n, sram_we_n, sram_ce_n,
        output sram_din
    );

endinterface

// File: rtl/sram_access_seq_addr_shift_cnt.sv
// Address register: serial MSB-first shift-in, increment with natural wrap, and clear.
module addr_shift_cnt
    import sram_seq_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              shift_en,
    input  logic              shift_bit,
    input  logic              inc,
    input  logic              clr,
    output logic [ADDR_W-1:0] addr
);

    logic [ADDR_W-1:0] addr_r;

    // Address update, priority clear > increment > shift
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            addr_r <= {ADDR_W{1'b0}};
        end else if (clr) begin
            addr_r <= {ADDR_W{1'b0}};
        end else if (inc) begin
            addr_r <= addr_r + {{(ADDR_W-1){1'b0}}, 1'b1};
        end else if (shift_en) begin
            addr_r <= {addr_r[ADDR_W-2:0], shift_bit};
        end else begin
            addr_r <= addr_r;
        end
    end

    assign addr = addr_r;

endmodule

// File: rtl/sram_access_seq.sv
// Clocked SRAM access engine: accepts one AVR command at a time and sequences the SRAM strobes
// with WAIT_CYCLES-long oe/we pulses. Strobes are registered, decoded from the next state.
module sram_access_seq
    import sram_seq_pkg::*;
#(
    parameter int ADDR_W      = ADDR_W_DEF,
    parameter int DATA_W      = DATA_W_DEF,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              avr_si,
    input  logic              avr_sreg_en,
    input  logic [2:0]        avr_ctrl,
    input  logic              cmd_valid,
    input  logic [DATA_W-1:0] avr_wdata,
    output logic [DATA_W-1:0] avr_rdata,
    output logic              rdata_valid,
    output logic              busy,
    output logic [7:0]        debug,
    sram_access_seq_if.master sram
);

    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

    logic [3:0]        state_r;
    logic [3:0]        next_state_s;
    logic [3:0]        wait_cnt_r;
    logic [2:0]        cmd_r;
    logic [DATA_W-1:0] rdata_r;
    logic [DATA_W-1:0] dout_r;
    logic              ce_n_r, oe_n_r, we_n_r, doe_r, busy_r, rvalid_r;
    logic              ce_n_s, oe_n_s, we_n_s, doe_s, busy_s, rvalid_s;
    logic              accept_s, wait_done_s, is_write_s, leaving_s;
    logic              shift_en_s, inc_s, clr_s;
    logic [ADDR_W-1:0] addr_s;

    assign accept_s    = cmd_valid && (state_r == ST_IDLE);
    assign wait_done_s = (wait_cnt_r == 4'd0);
    assign is_write_s  = (avr_ctrl == CMD_WRITE) || (avr_ctrl == CMD_WRITE_INC);
    assign leaving_s   = (state_r == ST_R_DONE) || (state_r == ST_W_HOLD);

    // A command in the same cycle as a shift request wins; the shifted bit is lost
    assign shift_en_s = (state_r == ST_IDLE) && !avr_sreg_en && !accept_s;
    assign inc_s      = (accept_s && (avr_ctrl == CMD_INC)) || (leaving_s && cmd_auto_inc(cmd_r));
    assign clr_s      = accept_s && (avr_ctrl == CMD_CLR);

    addr_shift_cnt #(.ADDR_W(ADDR_W)) u_addr (
        .clk       (clk),
        .reset     (reset),
        .shift_en  (shift_en_s),
        .shift_bit (avr_si),
        .inc       (inc_s),
        .clr       (clr_s),
        .addr      (addr_s)
    );

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= next_state_s;
        end
    end

    // Next-state decode
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (accept_s) begin
                    case (avr_ctrl)
                        CMD_READ, CMD_READ_INC:   next_state_s = ST_R_SETUP;
                        CMD_WRITE, CMD_WRITE_INC: next_state_s = ST_W_SETUP;
                        default:                  next_state_s = ST_IDLE;
                    endcase
                end else begin
                    next_state_s = ST_IDLE;
                end
            end
            ST_R_SETUP: next_state_s = ST_R_WAIT;
            ST_R_WAIT:  next_state_s = wait_done_s ? ST_R_DONE : ST_R_WAIT;
            ST_R_DONE:  next_state_s = ST_IDLE;
            ST_W_SETUP: next_state_s = ST_W_PULSE;
            ST_W_PULSE: next_state_s = wait_done_s ? ST_W_HOLD : ST_W_PULSE;
            ST_W_HOLD:  next_state_s = ST_IDLE;
            default:    next_state_s = ST_IDLE;
        endcase
    end

    // Strobe decode for the state about to be entered
    always_comb begin
        ce_n_s   = 1'b1;
        oe_n_s   = 1'b1;
        we_n_s   = 1'b1;
        doe_s    = 1'b0;
        rvalid_s = 1'b0;
        busy_s   = (next_state_s != ST_IDLE);
        case (next_state_s)
            ST_R_SETUP, ST_R_WAIT: begin
                ce_n_s = 1'b0;
                oe_n_s = 1'b0;
            end
            ST_R_DONE:  rvalid_s = 1'b1;
            ST_W_SETUP, ST_W_HOLD: begin
                ce_n_s = 1'b0;
                doe_s  = 1'b1;
            end
            ST_W_PULSE: begin
                ce_n_s = 1'b0;
                doe_s  = 1'b1;
                we_n_s = 1'b0;
            end
            default: busy_s = (next_state_s != ST_IDLE);
        endcase
    end

    // Output register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ce_n_r   <= 1'b1;
            oe_n_r   <= 1'b1;
            we_n_r   <= 1'b1;
            doe_r    <= 1'b0;
            busy_r   <= 1'b0;
            rvalid_r <= 1'b0;
        end else begin
            ce_n_r   <= ce_n_s;
            oe_n_r   <= oe_n_s;
            we_n_r   <= we_n_s;
            doe_r    <= doe_s;
            busy_r   <= busy_s;
            rvalid_r <= rvalid_s;
        end
    end

    // Wait counter, latched command and data paths
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wait_cnt_r <= WAIT_LOAD;
            cmd_r      <= CMD_NOP;
            rdata_r    <= {DATA_W{1'b0}};
            dout_r     <= {DATA_W{1'b0}};
        end else begin
            if ((state_r == ST_R_WAIT) || (state_r == ST_W_PULSE)) begin
                wait_cnt_r <= wait_done_s ? wait_cnt_r : (wait_cnt_r - 4'd1);
            end else begin
                wait_cnt_r <= WAIT_LOAD;
            end
            cmd_r   <= accept_s ? avr_ctrl : cmd_r;
            dout_r  <= (accept_s && is_write_s) ? avr_wdata : dout_r;
            rdata_r <= ((state_r == ST_R_WAIT) && wait_done_s) ? sram.sram_din : rdata_r;
        end
    end

    assign sram.sram_addr = addr_s;
    assign sram.sram_dout = dout_r;
    assign sram.sram_doe  = doe_r;
    assign sram.sram_oe_n = oe_n_r;
    assign sram.sram_we_n = we_n_r;
    assign sram.sram_ce_n = ce_n_r;
    assign avr_rdata      = rdata_r;
    assign rdata_valid    = rvalid_r;
    assign busy           = busy_r;
    assign debug          = {state_r, cmd_r, busy_r};

endmodule

// File: tb/tb_sram_access_seq.sv
// Directed bench for sram_access_seq with WAIT_CYCLES=2 and a small behavioural SRAM.
module tb_sram_access_seq;
    import sram_seq_pkg::*;

    localparam int AW = 21;
    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          avr_si = 1'b0;
    logic          avr_sreg_en = 1'b1;
    logic [2:0]    avr_ctrl = 3'd0;
    logic          cmd_valid = 1'b0;
    logic [DW-1:0] avr_wdata = 8'h00;
    logic [DW-1:0] avr_rdata;
    logic          rdata_valid;
    logic          busy;
    logic [7:0]    debug;

    int checks = 0;
    int errors = 0;

    sram_access_seq_if #(.ADDR_W(AW), .DATA_W(DW)) sram ();

    sram_access_seq #(.ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(2)) dut (
        .clk         (clk),
        .reset       (reset),
        .avr_si      (avr_si),
        .avr_sreg_en (avr_sreg_en),
        .avr_ctrl    (avr_ctrl),
        .cmd_valid   (cmd_valid),
        .avr_wdata   (avr_wdata),
        .avr_rdata   (avr_rdata),
        .rdata_valid (rdata_valid),
        .busy        (busy),
        .debug       (debug),
        .sram        (sram)
    );

    always #5 clk = ~clk;

    // SRAM model indexed by the low address nibble
    logic [7:0] mem [0:15];
    always @(posedge clk) begin
        if (!sram.sram_we_n && !sram.sram_ce_n) mem[sram.sram_addr[3:0]] <= sram.sram_dout;
    end
    assign sram.sram_din = (!sram.sram_ce_n && !sram.sram_oe_n) ? mem[sram.sram_addr[3:0]] : 8'h00;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift_in(input logic [20:0] v);
        for (int i = 20; i >= 0; i--) begin
            avr_sreg_en = 1'b0;
            avr_si      = v[i];
            tick();
        end
        avr_sreg_en = 1'b1;
        avr_si      = 1'b0;
    endtask

    task automatic issue(input logic [2:0] c, input logic [7:0] d);
        cmd_valid = 1'b1;
        avr_ctrl  = c;
        avr_wdata = d;
        tick();
        cmd_valid = 1'b0;
        avr_ctrl  = CMD_NOP;
    endtask

    int nb, nwe, ndoe, noe, nrv, rv_at, nbad;
    logic [7:0] rd_seen;

    initial begin
        // Reset state
        repeat (2) tick();
        reset = 1'b0;
        tick();
        chk("rst_busy", busy, 32'd0);
        chk("rst_strobes", {sram.sram_ce_n, sram.sram_oe_n, sram.sram_we_n, sram.sram_doe}, 32'hE);
        chk("rst_addr", sram.sram_addr, 32'h0);
        chk("rst_rdata", {avr_rdata, rdata_valid}, 32'h0);
        chk("rst_dout", sram.sram_dout, 32'h0);
        chk("rst_debug", debug, 32'h0);

        // Shift address then WRITE 0xA5
        shift_in(21'h12345);
        chk("shift_addr", sram.sram_addr, 32'h12345);
        issue(CMD_WRITE, 8'hA5);
        chk("write_debug", debug, {24'h0, ST_W_SETUP, CMD_WRITE, 1'b1});
        nb = 0; nwe = 0; ndoe = 0; nbad = 0;
        for (int k = 1; k <= 6; k++) begin
            if (busy) nb++;
            if (!sram.sram_we_n) nwe++;
            if (sram.sram_doe) ndoe++;
            if (sram.sram_addr != 21'h12345 || !sram.sram_oe_n ||
                (!sram.sram_we_n && sram.sram_dout != 8'hA5)) nbad++;
            tick();
        end
        chk("wr_busy_len", nb, 32'd4);
        chk("wr_we_len", nwe, 32'd2);
        chk("wr_doe_len", ndoe, 32'd4);
        chk("wr_addr_stable", nbad, 32'd0);

        // READ back
        issue(CMD_READ, 8'h00);
        noe = 0; nrv = 0; rv_at = 0; nbad = 0; rd_seen = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            if (!sram.sram_oe_n) noe++;
            if (rdata_valid) begin nrv++; rv_at = k; rd_seen = avr_rdata; end
            if (!sram.sram_oe_n && (sram.sram_doe || !sram.sram_we_n)) nbad++;
            tick();
        end
        chk("rd_oe_len", noe, 32'd3);
        chk("rd_valid_cnt", nrv, 32'd1);
        chk("rd_valid_pos", rv_at, 32'd4);
        chk("rd_data", rd_seen, 32'hA5);
        chk("rd_invariant", nbad, 32'd0);
        chk("rd_addr_kept", sram.sram_addr, 32'h12345);

        // WRITE_INC at the top address wraps to zero
        shift_in(21'h1FFFFF);
        chk("shift_ones", sram.sram_addr, 32'h1FFFFF);
        issue(CMD_WRITE_INC, 8'h3C);
        nwe = 0; nbad = 0;
        for (int k = 1; k <= 6; k++) begin
            if (!sram.sram_we_n) nwe++;
            if (busy && sram.sram_addr != 21'h1FFFFF) nbad++;
            tick();
        end
        chk("wi_we_len", nwe, 32'd2);
        chk("wi_addr_stable", nbad, 32'd0);
        chk("wi_wrap", sram.sram_addr, 32'h0);

        // Command and shift requests while busy are dropped
        issue(CMD_WRITE, 8'h77);
        nb = 0; noe = 0; nrv = 0; nbad = 0;
        for (int k = 1; k <= 7; k++) begin
            if (busy) nb++;
            if (!sram.sram_oe_n) noe++;
            if (rdata_valid) nrv++;
            if (sram.sram_addr != 21'h0) nbad++;
            avr_sreg_en = (k <= 4) ? 1'b0 : 1'b1;
            avr_si      = 1'b1;
            cmd_valid   = (k == 2);
            avr_ctrl    = CMD_READ;
            tick();
        end
        cmd_valid = 1'b0; avr_ctrl = CMD_NOP; avr_sreg_en = 1'b1; avr_si = 1'b0;
        chk("drop_busy_len", nb, 32'd4);
        chk("drop_no_read", noe + nrv, 32'd0);
        chk("drop_addr", nbad, 32'd0);

        // Asynchronous reset in the middle of W_PULSE
        shift_in(21'h00ABC);
        issue(CMD_WRITE, 8'h11);
        tick();
        chk("mid_we_low", sram.sram_we_n, 32'd0);
        #2 reset = 1'b1;
        #1;
        chk("arst_strobes", {sram.sram_ce_n, sram.sram_oe_n, sram.sram_we_n, sram.sram_doe}, 32'hE);
        chk("arst_busy", busy, 32'd0);
        chk("arst_addr", sram.sram_addr, 32'h0);
        chk("arst_rdata", avr_rdata, 32'h0);
        reset = 1'b0;
        tick();
        issue(CMD_READ, 8'h00);
        nrv = 0; rd_seen = 8'h00;
        for (int k = 1; k <= 6; k++) begin
            if (rdata_valid) begin nrv++; rd_seen = avr_rdata; end
            tick();
        end
        chk("post_rd_valid", nrv, 32'd1);
        chk("post_rd_data", rd_seen, 32'h77);

        // INC x3 then CLR, no SRAM activity
        nbad = 0;
        for (int i = 1; i <= 3; i++) begin
            issue(CMD_INC, 8'h00);
            chk("inc_addr", sram.sram_addr, i);
            if (busy || !sram.sram_ce_n || !sram.sram_oe_n || !sram.sram_we_n) nbad++;
        end
        issue(CMD_CLR, 8'h00);
        chk("clr_addr", sram.sram_addr, 32'h0);
        if (busy || !sram.sram_ce_n || !sram.sram_oe_n || !sram.sram_we_n) nbad++;
        tick();
        chk("inc_no_strobe", nbad, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sram_access_seq.md
Name: sram_access_seq

Overview:
- Sequences one AVR-initiated SRAM access per command: latches a serially shifted address, decodes the 3-bit AVR command, and generates SRAM strobe timing with programmable wait states.
- Optionally auto-increments the address after each access.
- Sits between the AVR-facing pins and the SRAM pins in the CPLD top level, feeding sram_addr, sram_data and the SRAM strobes directly.
- Replaces the free-running address shift/strobe pass-through path with a clocked access engine.

Parameters:
- ADDR_W, 21, SRAM address width.
- DATA_W, 8, data width.
- WAIT_CYCLES, 2, number of clk cycles the oe/we strobe is held low; legal range 1..15.

Ports:
- clk  in  1  system clock (AVR clock domain).
- reset  in  1  asynchronous, active-high reset.
- avr_si  in  1  serial address bit, MSB first.
- avr_sreg_en  in  1  active-low shift enable.
- avr_ctrl  in  3  command code.
- cmd_valid  in  1  one-cycle command strobe.
- avr_wdata  in  DATA_W  write data, sampled on command accept.
- avr_rdata  out  DATA_W  last read data.
- rdata_valid  out  1  one-cycle pulse when avr_rdata has been updated.
- busy  out  1  access in progress.
- sram_addr  out  ADDR_W  SRAM address.
- sram_din  in  DATA_W  SRAM data bus, input side.
- sram_dout  out  DATA_W  SRAM data bus, output side.
- sram_doe  out  1  SRAM data bus output enable (top level builds the tristate).
- sram_oe_n  out  1  SRAM output enable, active low.
- sram_we_n  out  1  SRAM write enable, active low.
- sram_ce_n  out  1  SRAM chip enable, active low.
- debug  out  8  {state[3:0], cmd[2:0], busy}.

Behaviour:
- Reset (async, immediate, including mid-access):
  - state=IDLE, addr=0, avr_rdata=0.
  - rdata_valid=0, busy=0, sram_doe=0.
  - sram_oe_n=1, sram_we_n=1, sram_ce_n=1.
  - sram_dout=0.
- Address shift: in IDLE with avr_sreg_en=0 and no command accepted that cycle, addr <= {addr[ADDR_W-2:0], avr_si} each clk.
  - Shift requests while busy=1 are ignored.
  - If cmd_valid and a shift occur in the same cycle, the command wins and the shift bit is dropped.
- Commands (avr_ctrl), accepted only when cmd_valid=1 and state=IDLE; cmd_valid while busy is dropped with no queueing:
  - 0 NOP.
  - 1 READ.
  - 2 WRITE.
  - 3 READ_INC.
  - 4 WRITE_INC.
  - 5 INC (addr+1, single cycle, no SRAM access).
  - 6 CLR (addr=0, single cycle).
  - 7 reserved, treated as NOP.
- FSM states: IDLE, R_SETUP, R_WAIT, R_DONE, W_SETUP, W_PULSE, W_HOLD.
- Read (commands 1/3):
  - R_SETUP, 1 cycle: ce_n=0, oe_n=0.
  - R_WAIT, WAIT_CYCLES cycles: ce_n=0, oe_n=0. sram_din is captured into avr_rdata on the last R_WAIT edge.
  - R_DONE, 1 cycle: ce_n=1, oe_n=1, rdata_valid=1.
  - Then IDLE.
- Write (commands 2/4): avr_wdata is latched into sram_dout at accept.
  - W_SETUP, 1 cycle: ce_n=0, doe=1.
  - W_PULSE, WAIT_CYCLES cycles: ce_n=0, doe=1, we_n=0.
  - W_HOLD, 1 cycle: ce_n=0, doe=1, we_n=1.
  - Then IDLE with doe=0 and ce_n=1.
- busy = (state != IDLE).
  - Asserted from the cycle after accept.
  - Length is WAIT_CYCLES+2 cycles for both READ and WRITE.
- Auto-increment (commands 3/4): addr+1 is applied on the edge leaving R_DONE or W_HOLD. sram_addr is stable for the whole access.
- Address wrap: 2^ADDR_W-1 + 1 wraps to 0, with no flag.
- Invariants:
  - oe_n and we_n are never low simultaneously.
  - doe=0 whenever oe_n=0.
  - WAIT counter is 4 bits, loaded with WAIT_CYCLES-1 and counted down to 0.

Decomposition:
- Package sram_seq_pkg holds:
  - command codes CMD_NOP … CMD_CLR;
  - the state encoding (4-bit localparams);
  - the default ADDR_W/DATA_W.
- One natural sub-module: addr_shift_cnt, the ADDR_W shift register with load-increment/clear and wrap. The FSM lives in sram_access_seq.

Test Plan (WAIT_CYCLES=2):
- Shift 21 bits of 0x12345 MSB first, then WRITE with 0xA5 → busy for 4 cycles; we_n low for exactly 2 cycles; sram_addr=0x12345 throughout; doe high for 4 cycles.
- READ at 0x12345 with an SRAM model holding 0xA5 → oe_n low for 3 cycles; rdata_valid pulses once, 4 cycles after accept; avr_rdata=0xA5; addr unchanged.
- Shift 0x1FFFFF, then WRITE_INC → write goes to 0x1FFFFF; afterwards sram_addr=0x000000 (wrap).
- cmd_valid READ issued in the 2nd busy cycle of a WRITE, plus avr_sreg_en=0 during busy → second command ignored; addr unchanged; only one access observed.
- Assert reset in the middle of W_PULSE → we_n, ce_n and oe_n go high and doe=0 asynchronously; addr=0, busy=0; a subsequent READ works normally.
- INC ×3 from 0, then CLR → addr goes 1, 2, 3, then 0; no SRAM strobe ever asserted; busy stays 0.
